vec_inst_issue_queue: RTL
=========================

// Module: vec_inst_issue_queue
// PURPOSE
//  Sender side of the vec_inst interface: buffers vector instructions and their scalar operands from the scalar core,
//  then issues them one at a time, in order, to vector_processor_controller and the vector datapath.
//  Holds each instruction stable until the vector unit signals completion. Drops non-vector opcodes.
//  Flags a vector unit that never signals completion.
// PARAMETERS
//  XLEN            32    instruction / scalar operand width
//  DEPTH           4     FIFO entries; power of 2, >=2
//  TIMEOUT_CYCLES  1024  max cycles in WAIT_DONE before abort; 0 disables the watchdog
// PORTS
//  clk              in   1               clock, rising edge
//  reset            in   1               asynchronous, active-high
//  flush            in   1               synchronous clear of queue and FSM
//  scalar_valid     in   1               scalar core offers an instruction
//  scalar_ready     out  1               queue can accept
//  scalar_inst      in   XLEN            raw instruction
//  scalar_rs1_data  in   XLEN            rs1 value captured with the instruction
//  scalar_rs2_data  in   XLEN            rs2 value captured with the instruction
//  vec_inst         out  XLEN            to controller; 0 when no instruction is in flight
//  vec_rs1_data     out  XLEN            operand paired with vec_inst; 0 when no instruction is in flight
//  vec_rs2_data     out  XLEN            operand paired with vec_inst; 0 when no instruction is in flight
//  vec_inst_valid   out  1               1-cycle pulse: new instruction presented
//  vec_done         in   1               vector unit finished current instruction (pulse)
//  vec_busy         out  1               instruction in flight
//  illegal_inst     out  1               1-cycle pulse: non-vector opcode dropped
//  timeout_err      out  1               sticky until reset/flush
//  queue_count      out  $clog2(DEPTH)+1 valid entries, including the in-flight head
// BEHAVIOUR
//  Reset: all outputs 0, except scalar_ready=1. FIFO empty, state IDLE, watchdog counter 0.
//  Push:
//   - Fires when scalar_valid && scalar_ready.
//   - scalar_ready = (queue_count < DEPTH). Comes from registers only; there is no path from vec_done.
//  Opcode filter:
//   - Legal opcodes [6:0]: V_ARITH 7'h57, V_LOAD 7'h07, V_STORE 7'h27.
//   - Any other opcode is accepted but not stored. illegal_inst pulses the next cycle.
//  Push and pop in the same cycle: queue_count unchanged; pointers wrap mod DEPTH.
//  FSM:
//   - IDLE -> ISSUE when the FIFO is non-empty.
//   - ISSUE, one cycle:
//     - vec_inst and rs data = FIFO head; vec_inst_valid=1; vec_busy=1.
//     - vec_done=1 in ISSUE: pop, go to ISSUE if more entries remain, else IDLE.
//     - vec_done=0 in ISSUE: go to WAIT_DONE.
//   - WAIT_DONE:
//     - vec_inst and rs data held stable; vec_inst_valid=0; vec_busy=1.
//     - The controller decodes combinationally, so its outputs stay stable for the whole execution.
//     - On vec_done: pop; next state ISSUE if count after pop > 0, else IDLE.
//   - Head is popped on completion, not on issue. queue_count therefore includes the in-flight instruction.
//  Latency:
//   - Push into an empty, idle queue -> vec_inst_valid 2 cycles later.
//     - Cycle 1: entry registered. Cycle 2: ISSUE.
//   - Back-to-back instructions: ISSUE follows the done cycle directly; no idle bubble.
//  vec_inst and rs data are 0 in IDLE, so the controller sees a no-op with all enables 0.
//  vec_done in IDLE is ignored.
//  Watchdog:
//   - Counter clears on entry to WAIT_DONE and increments each WAIT_DONE cycle.
//   - On reaching TIMEOUT_CYCLES without vec_done: set timeout_err, pop the head, go to IDLE or ISSUE.
//  Flush:
//   - Empties the FIFO; state -> IDLE; outputs -> reset values; timeout_err cleared.
//   - Has priority over a same-cycle push; that push is discarded even though scalar_ready is 1.
//   - Has priority over a same-cycle vec_done.
//  Reset mid-operation: immediate return to reset state; in-flight and queued instructions are lost.
// TESTING
//  1. Push vadd.vv 32'h0201_0057, vec_done 3 cycles after issue:
//     vec_inst_valid 2 cycles after push; vec_inst held 4 cycles (1 ISSUE + 3 WAIT_DONE); then 0, vec_busy=0.
//  2. Push 5 instructions back-to-back, DEPTH=4, vec_done withheld:
//     scalar_ready=0 after 4 pushes; queue_count=4; 5th stalls until the first vec_done, then is accepted.
//  3. Push opcode 7'h33 (scalar add): scalar_ready=1; illegal_inst pulses once; queue_count stays 0; no issue.
//  4. Queue holds 2; vec_done asserted in the ISSUE cycle of each:
//     2 consecutive vec_inst_valid pulses, 1 cycle apart; queue empties.
//  5. TIMEOUT_CYCLES=8, vec_done never asserted:
//     timeout_err=1 after 8 WAIT_DONE cycles; head dropped; next entry issued.
//  6. flush with a push and vec_done in the same cycle, queue holding 3:
//     queue_count=0; vec_inst=0; state IDLE; pushed instruction never issued.

Source files
------------

// File: rtl/vec_inst_issue_queue_if.sv
// Handshake bundle between the scalar core, the vector issue queue and the vector unit.
// master: the issue queue; slave: the scalar core / vector unit side.
interface vec_inst_issue_queue_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic            flush;
  logic            scalar_valid;
  logic            scalar_ready;
  logic [XLEN-1:0] scalar_inst;
  logic [XLEN-1:0] scalar_rs1_data;
  logic [XLEN-1:0] scalar_rs2_data;
  logic [XLEN-1:0] vec_inst;
  logic [XLEN-1:0] vec_rs1_data;
  logic [XLEN-1:0] vec_rs2_data;
  logic            vec_inst_valid;
  logic            vec_done;
  logic            vec_busy;
  logic            illegal_inst;
  logic            timeout_err;
  logic [CntW-1:0] queue_count;

  modport master (
    input  flush,
    input  scalar_valid,
    output scalar_ready,
    input  scalar_inst,
    input  scalar_rs1_data,
    input  scalar_rs2_data,
    output vec_inst,
    output vec_rs1_data,
    output vec_rs2_data,
    output vec_inst_valid,
    input  vec_done,
    output vec_busy,
    output illegal_inst,
    output timeout_err,
    output queue_count
  );

  modport slave (
    output flush,
    output scalar_valid,
    input  scalar_ready,
    output scalar_inst,
    output scalar_rs1_data,
    output scalar_rs2_data,
    input  vec_inst,
    input  vec_rs1_data,
    input  vec_rs2_data,
    input  vec_inst_valid,
    output vec_done,
    input  vec_busy,
    input  illegal_inst,
    input  timeout_err,
    input  queue_count
  );
endinterface

// File: rtl/vec_inst_issue_queue.sv
// In-order vector instruction issue queue: buffers vector instructions with their scalar operands and
// presents them one at a time, holding each until the vector unit completes or the watchdog fires.
module vec_inst_issue_queue #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input logic                  clk,
  input logic                  reset,
  vec_inst_issue_queue_if.master bus
);

  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned CntW   = $clog2(DEPTH) + 1;
  localparam int unsigned WdW    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned WdLast = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  localparam logic [6:0] OpVArith = 7'h57;
  localparam logic [6:0] OpVLoad  = 7'h07;
  localparam logic [6:0] OpVStore = 7'h27;

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e          state_q, state_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [WdW-1:0]  wd_q, wd_d;
  logic            timeout_q, timeout_d;
  logic            illegal_q, illegal_d;

  logic [XLEN-1:0] inst_mem [DEPTH];
  logic [XLEN-1:0] rs1_mem  [DEPTH];
  logic [XLEN-1:0] rs2_mem  [DEPTH];

  logic [6:0] opcode;
  logic       legal;
  logic       accept;
  logic       push;
  logic       pop;
  logic       in_flight;

  assign opcode = bus.scalar_inst[6:0];
  assign legal  = (opcode == OpVArith) || (opcode == OpVLoad) || (opcode == OpVStore);

  // Flush wins over a same-cycle push even though scalar_ready may be high.
  assign accept = bus.scalar_valid && bus.scalar_ready && !bus.flush;
  assign push   = accept && legal;

  always_comb begin
    state_d   = state_q;
    wd_d      = wd_q;
    timeout_d = timeout_q;
    pop       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (count_q != '0) state_d = StIssue;
      end
      StIssue: begin
        if (bus.vec_done) begin
          pop = 1'b1;
        end else begin
          state_d = StWait;
          wd_d    = '0;
        end
      end
      StWait: begin
        wd_d = wd_q + WdW'(1);
        if (bus.vec_done) begin
          pop = 1'b1;
        end else if ((TIMEOUT_CYCLES != 0) && (wd_q == WdW'(WdLast))) begin
          pop       = 1'b1;
          timeout_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    count_d  = count_q + CntW'(push) - CntW'(pop);
    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    illegal_d = accept && !legal;

    // Completion counts a same-cycle push, so the next issue follows with no bubble.
    if (pop) state_d = (count_d != '0) ? StIssue : StIdle;

    if (bus.flush) begin
      state_d   = StIdle;
      count_d   = '0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      wd_d      = '0;
      timeout_d = 1'b0;
      illegal_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      wd_q      <= '0;
      timeout_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
      illegal_q <= illegal_d;
    end
  end

  // Payload storage needs no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr_q] <= bus.scalar_inst;
      rs1_mem[wr_ptr_q]  <= bus.scalar_rs1_data;
      rs2_mem[wr_ptr_q]  <= bus.scalar_rs2_data;
    end
  end

  assign in_flight = (state_q != StIdle);

  assign bus.scalar_ready   = (count_q < CntW'(DEPTH));
  assign bus.vec_inst       = in_flight ? inst_mem[rd_ptr_q] : '0;
  assign bus.vec_rs1_data   = in_flight ? rs1_mem[rd_ptr_q]  : '0;
  assign bus.vec_rs2_data   = in_flight ? rs2_mem[rd_ptr_q]  : '0;
  assign bus.vec_inst_valid = (state_q == StIssue);
  assign bus.vec_busy       = in_flight;
  assign bus.illegal_inst   = illegal_q;
  assign bus.timeout_err    = timeout_q;
  assign bus.queue_count    = count_q;

endmodule
